// File: rtl/matmul_output_collector_if.sv
// Result stream from the output collector toward softmax / the output buffer.
// The master drives data/valid/last and the slave drives ready.
interface matmul_output_collector_if #(
  parameter int BEAT_W = 256
);
  logic [BEAT_W-1:0] out_tdata;
  logic              out_tvalid;
  logic              out_tready;
  logic              out_tlast;

  modport master (output out_tdata, output out_tvalid, output out_tlast, input out_tready);
  modport slave  (input out_tdata, input out_tvalid, input out_tlast, output out_tready);
endinterface

// File: rtl/matmul_output_collector.sv
// Captures the wrapper's per-row results on acc_done_wrap and streams them out beat by beat.
// Define COLLECT_PINGPONG_EN for two alternating capture buffers (default: single buffer).
//
// state | meaning
// IDLE  | no buffer holds undrained data
// DRAIN | presenting beats of the tile in buffer rd_ptr
module matmul_output_collector #(
  parameter int WIDTH_OUT     = 16,
  parameter int CHUNK_SIZE    = 4,
  parameter int NUM_CORES_A   = 4,
  parameter int NUM_CORES_B   = 1,
  parameter int TOTAL_MODULES = 2,
  parameter int TOTAL_INPUT_W = 2,
  localparam int BEAT_W       = WIDTH_OUT * CHUNK_SIZE * NUM_CORES_A * NUM_CORES_B,
  localparam int ROW_W        = BEAT_W * TOTAL_MODULES
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         acc_done_wrap,
  input  logic [ROW_W-1:0]             in_data [TOTAL_INPUT_W],
  matmul_output_collector_if.master    out_if,
  output logic                         busy,
  output logic                         overflow,
  input  logic                         clr_overflow
);

  localparam int NUM_BEATS = TOTAL_INPUT_W * TOTAL_MODULES;
  localparam int CNT_W     = (NUM_BEATS > 1) ? $clog2(NUM_BEATS) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_BEATS - 1);

  typedef enum logic {IDLE, DRAIN} state_t;

  state_t            state;
  // Two slots always exist; without ping-pong only slot 0 is ever written.
  logic [BEAT_W-1:0] tile_q [2][NUM_BEATS];
  logic [1:0]        full_q;
  logic              wr_ptr;
  logic              rd_ptr;
  logic [CNT_W-1:0]  cnt;
  logic              acc_d;

  logic              trig, xfer, last_xfer, can_accept, accept, drop;
  logic [1:0]        full_nxt;
  logic [CNT_W-1:0]  cnt_nxt;

  always_comb begin
    trig       = acc_done_wrap & ~acc_d;
    xfer       = (state == DRAIN) & out_if.out_tready;
    last_xfer  = xfer & (cnt == LAST_CNT);
    // The slot being drained can be refilled on the edge its last beat leaves.
    can_accept = ~full_q[wr_ptr] | (last_xfer & (rd_ptr == wr_ptr));
    accept     = trig & can_accept;
    drop       = trig & ~can_accept;

    full_nxt = full_q;
    if (last_xfer) full_nxt[rd_ptr] = 1'b0;
    if (accept)    full_nxt[wr_ptr] = 1'b1;

    cnt_nxt = cnt;
    if (xfer) cnt_nxt = last_xfer ? '0 : cnt + 1'b1;
  end

  assign out_if.out_tdata = tile_q[rd_ptr][cnt];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state             <= IDLE;
      full_q            <= '0;
      wr_ptr            <= 1'b0;
      rd_ptr            <= 1'b0;
      cnt               <= '0;
      acc_d             <= 1'b0;
      out_if.out_tvalid <= 1'b0;
      out_if.out_tlast  <= 1'b0;
      busy              <= 1'b0;
      overflow          <= 1'b0;
      for (int s = 0; s < 2; s++)
        for (int b = 0; b < NUM_BEATS; b++)
          tile_q[s][b] <= '0;
    end else begin
      acc_d  <= acc_done_wrap;
      full_q <= full_nxt;
      cnt    <= cnt_nxt;

      if (accept)
        for (int b = 0; b < NUM_BEATS; b++)
          tile_q[wr_ptr][b] <= in_data[b / TOTAL_MODULES][(b % TOTAL_MODULES) * BEAT_W +: BEAT_W];

`ifdef COLLECT_PINGPONG_EN
      if (accept)    wr_ptr <= ~wr_ptr;
      if (last_xfer) rd_ptr <= ~rd_ptr;
`else
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
`endif

      state             <= (|full_nxt) ? DRAIN : IDLE;
      out_if.out_tvalid <= |full_nxt;
      out_if.out_tlast  <= (|full_nxt) & (cnt_nxt == LAST_CNT);
      busy              <= |full_nxt;

      if (drop)              overflow <= 1'b1;
      else if (clr_overflow) overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_matmul_output_collector.sv
// Randomized scoreboard bench for matmul_output_collector; a tile-level model predicts
// accepted tiles, overflow and the expected beat sequence.
module tb_matmul_output_collector;
  localparam int WIDTH_OUT     = 16;
  localparam int CHUNK_SIZE    = 4;
  localparam int NUM_CORES_A   = 4;
  localparam int NUM_CORES_B   = 1;
  localparam int TOTAL_MODULES = 2;
  localparam int TOTAL_INPUT_W = 2;
  localparam int BEAT_W = WIDTH_OUT * CHUNK_SIZE * NUM_CORES_A * NUM_CORES_B;
  localparam int ROW_W  = BEAT_W * TOTAL_MODULES;
  localparam int NB     = TOTAL_INPUT_W * TOTAL_MODULES;
`ifdef COLLECT_PINGPONG_EN
  localparam int CAP = 2;
`else
  localparam int CAP = 1;
`endif

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             acc = 1'b0;
  logic             clr = 1'b0;
  logic [ROW_W-1:0] in_data [TOTAL_INPUT_W];
  logic             busy, overflow;

  matmul_output_collector_if #(.BEAT_W(BEAT_W)) sif ();

  matmul_output_collector #(
    .WIDTH_OUT(WIDTH_OUT), .CHUNK_SIZE(CHUNK_SIZE), .NUM_CORES_A(NUM_CORES_A),
    .NUM_CORES_B(NUM_CORES_B), .TOTAL_MODULES(TOTAL_MODULES), .TOTAL_INPUT_W(TOTAL_INPUT_W)
  ) dut (
    .clk(clk), .rst(rst), .acc_done_wrap(acc), .in_data(in_data),
    .out_if(sif), .busy(busy), .overflow(overflow), .clr_overflow(clr)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Reference model: tiles waiting or in flight, beats of the current tile already sent.
  logic [BEAT_W-1:0] exp_q [$];
  int pending = 0;
  int beat = 0;
  bit ovf_m = 1'b0;
  bit acc_prev = 1'b0;

  task automatic check(string name, logic [BEAT_W-1:0] act, logic [BEAT_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Model: compare state after the last edge, then predict the coming edge.
  always @(negedge clk) begin : model_p
    bit xfer, lastx, trig, drop;
    if (!rst) begin
      check("valid", sif.out_tvalid, pending > 0);
      check("busy", busy, pending > 0);
      check("tlast", sif.out_tlast, (pending > 0) && (beat == NB - 1));
      check("overflow", overflow, ovf_m);
      xfer  = sif.out_tvalid && sif.out_tready;
      lastx = xfer && (pending > 0) && (beat == NB - 1);
      if (xfer && pending > 0) begin
        if (lastx) begin
          beat = 0;
          pending--;
        end else beat++;
      end
      trig = acc && !acc_prev;
      drop = 1'b0;
      if (trig) begin
        if (pending < CAP) begin
          pending++;
          for (int r = 0; r < TOTAL_INPUT_W; r++)
            for (int s = 0; s < TOTAL_MODULES; s++)
              exp_q.push_back(in_data[r][s*BEAT_W +: BEAT_W]);
        end else drop = 1'b1;
      end
      if (drop) ovf_m = 1'b1;
      else if (clr) ovf_m = 1'b0;
      acc_prev = acc;
    end
  end

  // Monitor: pops the scoreboard on every transfer and checks hold-while-stalled.
  logic [BEAT_W-1:0] prev_d;
  bit prev_v = 1'b0, prev_r = 1'b0, prev_l = 1'b0;
  always @(negedge clk) begin
    if (rst) prev_v = 1'b0;
    else begin
      if (prev_v && !prev_r) begin
        check("hold_valid", sif.out_tvalid, 1'b1);
        check("hold_data", sif.out_tdata, prev_d);
        check("hold_last", sif.out_tlast, prev_l);
      end
      if (sif.out_tvalid && sif.out_tready) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL beat_unexpected actual=%h required=no_beat", sif.out_tdata);
        end else check("beat_data", sif.out_tdata, exp_q.pop_front());
      end
      prev_v = sif.out_tvalid;
      prev_r = sif.out_tready;
      prev_l = sif.out_tlast;
      prev_d = sif.out_tdata;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_tile();
    for (int r = 0; r < TOTAL_INPUT_W; r++)
      for (int w = 0; w < ROW_W / 32; w++)
        in_data[r][w*32 +: 32] = $urandom();
  endtask

  task automatic pulse();
    acc = 1'b1;
    step();
    acc = 1'b0;
  endtask

  task automatic wait_idle(int maxc);
    int n = 0;
    while (pending > 0 && n < maxc) begin
      step();
      n++;
    end
    checks++;
    if (pending > 0) begin
      failures++;
      $display("FAIL drain_timeout actual=%0d tiles_pending required=0", pending);
    end
  endtask

  initial begin
    for (int r = 0; r < TOTAL_INPUT_W; r++) in_data[r] = '0;
    sif.out_tready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_tvalid", sif.out_tvalid, 1'b0);
    check("rst_tlast", sif.out_tlast, 1'b0);
    check("rst_tdata", sif.out_tdata, '0);
    check("rst_busy", busy, 1'b0);
    check("rst_overflow", overflow, 1'b0);
    rst = 1'b0;

    // Basic drain with distinct constant beats A0,B1,C2,D3.
    in_data[0] = {{(BEAT_W/16){16'hB1B1}}, {(BEAT_W/16){16'hA0A0}}};
    in_data[1] = {{(BEAT_W/16){16'hD3D3}}, {(BEAT_W/16){16'hC2C2}}};
    sif.out_tready = 1'b1;
    repeat (5) step();
    pulse();
    wait_idle(20);
    repeat (2) step();

    // Backpressure with ready pattern 1,0,0,1.
    rand_tile();
    pulse();
    for (int i = 0; i < 16; i++) begin
      sif.out_tready = (i % 4 == 0) || (i % 4 == 3);
      step();
    end
    sif.out_tready = 1'b1;
    wait_idle(20);

    // Level held high: a single tile.
    rand_tile();
    acc = 1'b1;
    repeat (20) step();
    acc = 1'b0;
    wait_idle(20);

    // Second edge during beat 1, then clear overflow.
    rand_tile();
    pulse();
    step();
    rand_tile();
    pulse();
    wait_idle(40);
    clr = 1'b1;
    step();
    clr = 1'b0;
    step();

    // Second edge exactly on the last-beat transfer: back-to-back tiles.
    rand_tile();
    pulse();
    repeat (3) step();
    rand_tile();
    pulse();
    wait_idle(40);

    // Triggers two cycles apart with output stalled; third edge finds no free buffer.
    sif.out_tready = 1'b0;
    rand_tile();
    pulse();
    step();
    rand_tile();
    pulse();
    step();
    rand_tile();
    pulse();
    step();
    sif.out_tready = 1'b1;
    wait_idle(40);
    clr = 1'b1;
    step();
    clr = 1'b0;

    // Async reset after two beats, then restart.
    rand_tile();
    pulse();
    step();
    step();
    #2;
    rst = 1'b1;
    #1;
    check("rst_mid_tvalid", sif.out_tvalid, 1'b0);
    check("rst_mid_busy", busy, 1'b0);
    check("rst_mid_tlast", sif.out_tlast, 1'b0);
    exp_q.delete();
    pending = 0;
    beat = 0;
    ovf_m = 1'b0;
    acc_prev = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    rand_tile();
    pulse();
    wait_idle(20);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      acc = ($urandom_range(0, 4) == 0);
      sif.out_tready = ($urandom_range(0, 3) != 0);
      clr = ($urandom_range(0, 15) == 0);
      rand_tile();
      step();
    end
    acc = 1'b0;
    clr = 1'b0;
    sif.out_tready = 1'b1;
    wait_idle(60);
    repeat (2) step();
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL leftover_beats actual=%0d required=0", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/matmul_output_collector.md
Name: matmul_output_collector

Overview:
- Drain side of the multi-matmul wrapper: captures the per-row result array when accumulation completes, then serializes it onto a valid/ready stream toward the next stage (softmax / output buffer).
- Frees the wrapper's wide parallel outputs for the next tile.
- Sits directly after the wrapper and shares its clock domain.

Parameters:
- WIDTH_OUT, 16, element width.
- CHUNK_SIZE, 4, elements per chunk.
- NUM_CORES_A, 4, A-side cores.
- NUM_CORES_B, 1, B-side cores.
- TOTAL_MODULES, 2, matmul modules per row; also the beats per row.
- TOTAL_INPUT_W, 2, rows (wrapper instances).
- Derived (localparam): BEAT_W = WIDTH_OUT*CHUNK_SIZE*NUM_CORES_A*NUM_CORES_B.
- Derived: ROW_W = BEAT_W*TOTAL_MODULES.
- Derived: NUM_BEATS = TOTAL_INPUT_W*TOTAL_MODULES.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- acc_done_wrap  in  1  accumulation-complete level from wrapper.
- in_data  in  ROW_W x [TOTAL_INPUT_W]  unpacked array, row i = wrapper output i.
- out_tdata  out  BEAT_W  stream data.
- out_tvalid  out  1  stream valid.
- out_tready  in  1  downstream ready.
- out_tlast  out  1  high on final beat of a tile.
- busy  out  1  at least one buffer holds undrained data.
- overflow  out  1  sticky: a completion was dropped.
- clr_overflow  in  1  synchronous clear of overflow.

Behaviour:
- Reset: every output is 0. FSM = IDLE. Beat counter = 0. Capture buffer(s) cleared. Edge-detect register = 0.
- Capture trigger: rising edge of acc_done_wrap (acc_done_wrap=1 and previous-cycle sample=0). A level held high for multiple cycles triggers exactly once.
- FSM IDLE:
  - On trigger, register in_data into the buffer at that clock edge and go to DRAIN.
  - out_tvalid rises the next cycle. Trigger at edge N gives first beat valid at N+1.
- FSM DRAIN:
  - out_tdata = buffer row (cnt / TOTAL_MODULES), slice (cnt % TOTAL_MODULES).
  - Slice 0 is bits [BEAT_W-1:0], i.e. LSB slice first, row 0 first.
- Handshake:
  - A beat transfers when out_tvalid && out_tready.
  - The counter increments only on transfer.
  - out_tdata, out_tvalid and out_tlast are stable while out_tvalid=1 and out_tready=0.
  - out_tvalid never drops without a transfer.
- Last beat:
  - out_tlast=1 exactly when cnt == NUM_BEATS-1.
  - On its transfer, cnt wraps to 0. The FSM returns to IDLE, or stays in DRAIN if another buffer is full (optional feature).
- busy = 1 whenever any buffer is full, including the capture cycle's next state.
- Simultaneous events:
  - A trigger in the same cycle as the last-beat transfer is accepted: the buffer is freed and refilled in that edge, and out_tvalid stays high with cnt=0.
  - A trigger while no buffer is free is dropped, and overflow <= 1.
  - clr_overflow and a drop in the same cycle: overflow = 1 (set wins).
- Reset mid-drain: stream is abandoned. out_tvalid = 0 immediately (async), buffered data discarded.
- No arithmetic: the data path is pure slicing and mux. Width mismatches are illegal; parameters are only consistent if NUM_BEATS >= 1.

Optional Feature:
- Macro COLLECT_PINGPONG_EN.
- Defined:
  - Two capture buffers, written alternately with a write pointer and read from a read pointer.
  - A trigger during DRAIN is accepted if the other buffer is empty.
  - After a last-beat transfer with the other buffer full, the next tile's beat 0 is presented the following cycle with no bubble (out_tvalid stays 1).
  - overflow is set only when both buffers are full.
- Undefined:
  - Single buffer.
  - Any trigger during DRAIN other than the last-beat-transfer cycle is dropped and sets overflow.

Test Plan (defaults, BEAT_W=256, NUM_BEATS=4):
- Basic drain:
  - Stimulus: in_data[0]={B1,A0}, in_data[1]={D3,C2} (each 256-bit slice filled with a distinct constant). acc_done pulse at cycle 10, out_tready=1.
  - Required: beats A0,B1,C2,D3 on cycles 11-14; out_tlast only on cycle 14; busy falls after cycle 14.
- Backpressure:
  - Stimulus: same tile, out_tready toggles 1,0,0,1,...
  - Required: data/valid/last held stable during ready=0; exactly 4 transfers in order; no duplicates.
- Level hold:
  - Stimulus: acc_done_wrap held high 20 cycles.
  - Required: exactly one tile (4 beats) emitted; overflow stays 0.
- Drop and clear (macro undefined):
  - Stimulus: second rising edge during beat 1 with ready=1.
  - Required: overflow=1 and only 4 beats total. clr_overflow pulse then gives overflow=0.
  - Repeat with a second edge on the exact last-beat transfer cycle: 8 beats, no gap, overflow=0.
- Ping-pong (macro defined):
  - Stimulus: two tiles with triggers 2 cycles apart, ready=1.
  - Required: 8 contiguous beats, out_tlast on beats 4 and 8, overflow=0.
  - A third trigger while both buffers are full sets overflow.
- Async reset mid-drain:
  - Stimulus: assert rst after beat 2.
  - Required: out_tvalid=0, busy=0, cnt=0 without a clock edge.
  - A new trigger after release restarts at beat A0.
